// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode constants and sequencer state shared by the PC sequencer files
package cpu_pkg;
    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00100;
    localparam logic [4:0] OP_JR   = 5'b00101;
    localparam logic [4:0] OP_JAL  = 5'b00110;
    localparam logic [4:0] OP_JALR = 5'b00111;
    localparam logic [4:0] OP_BEQZ = 5'b01100;
    localparam logic [4:0] OP_BNEZ = 5'b01101;
    localparam logic [4:0] OP_BLTZ = 5'b01110;
    localparam logic [4:0] OP_BGEZ = 5'b01111;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT, S_ERR} state_t;

    function automatic logic is_link(input logic [4:0] op);
        return op == OP_JAL || op == OP_JALR;
    endfunction
endpackage

// File: rtl/npc_calc.sv
// npc_calc: combinational next-PC and link-enable for the retiring instruction
module npc_calc
    import cpu_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic [PC_W-1:0] pc,
    input  logic [15:0]     instr,
    input  logic [15:0]     rs_data,
    output logic [PC_W-1:0] npc,
    output logic [PC_W-1:0] pc_inc,
    output logic            link
);
    logic [4:0]      op;
    logic [PC_W-1:0] d11, d8;
    logic            taken;
    always_comb begin
        op     = instr[15:11];
        pc_inc = pc + PC_W'(2);
        d11    = PC_W'($signed(instr[10:0]));
        d8     = PC_W'($signed(instr[7:0]));
        taken  = (op == OP_BEQZ) ? (rs_data == '0) :
                 (op == OP_BNEZ) ? (rs_data != '0) :
                 (op == OP_BLTZ) ? rs_data[15] :
                 (op == OP_BGEZ) && !rs_data[15];
        link   = is_link(op);
        npc    = (op == OP_HALT)                 ? pc :
                 (op == OP_J  || op == OP_JAL)   ? pc_inc + d11 :
                 (op == OP_JR || op == OP_JALR)  ? PC_W'(rs_data) + d8 :
                 taken                           ? pc_inc + d8 : pc_inc;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC and sequences fetch, execute hand-off and next-PC selection
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W          = 16,
    parameter logic [PC_W-1:0] RESET_PC      = '0,
    parameter int              FETCH_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [15:0]     imem_data,
    output logic            instr_valid,
    output logic [15:0]     instr_out,
    input  logic            ex_done,
    input  logic [15:0]     rs_data,
    output logic            link_we,
    output logic [15:0]     link_data,
    output logic            halted,
    output logic            err
);
    localparam int            CW       = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FETCH_TIMEOUT - 1);

    state_t          state;
    logic [PC_W-1:0] pc, npc, pc_inc;
    logic [CW-1:0]   cnt;
    logic            link;

    assign imem_addr = pc;

    npc_calc #(.PC_W(PC_W)) u_npc (
        .pc      (pc),
        .instr   (instr_out),
        .rs_data (rs_data),
        .npc     (npc),
        .pc_inc  (pc_inc),
        .link    (link)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            cnt         <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            link_we     <= 1'b0;
            link_data   <= '0;
            halted      <= 1'b0;
            err         <= 1'b0;
        end else begin
            link_we <= 1'b0;
            case (state)
                S_FETCH:
                    // a ready arriving on the last counted cycle still completes the fetch
                    if (imem_ready) begin
                        instr_out   <= imem_data;
                        cnt         <= '0;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= S_EXEC;
                    end else if (cnt == CNT_LAST) begin
                        imem_req <= 1'b0;
                        err      <= 1'b1;
                        state    <= S_ERR;
                    end else begin
                        cnt      <= cnt + CW'(1);
                        imem_req <= 1'b1;
                    end
                S_EXEC:
                    if (ex_done) begin
                        pc          <= npc;
                        instr_valid <= 1'b0;
                        link_we     <= link;
                        if (link) link_data <= 16'(pc_inc);
                        if (instr_out[15:11] == OP_HALT) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                    end
                default: ;
            endcase
        end
    end
endmodule
